// File: rtl/ecc_pkg.sv
// ecc_pkg
//   Shared definitions for the SECDED encode/decode path.
//   - get_parity_width(): number of Hamming parity bits p for a data width,
//     the smallest p with 2^p >= data_width + p + 1.
//   - get_cw_width(): Hamming code-word width (data + parity, without the
//     overall parity bit).
//   - inj_mode_e: error-injection modes carried alongside a data beat.
package ecc_pkg;

    typedef enum logic [1:0] {
        INJ_NONE   = 2'b00,
        INJ_SINGLE = 2'b01,
        INJ_DOUBLE = 2'b10,
        INJ_PARITY = 2'b11
    } inj_mode_e;

    function automatic int get_parity_width(input int data_width);
        int p;
        p = 1;
        while ((1 << p) < (data_width + p + 1)) begin
            p = p + 1;
        end
        return p;
    endfunction

    function automatic int get_cw_width(input int data_width);
        return data_width + get_parity_width(data_width);
    endfunction

endpackage

// File: rtl/ecc_encode.sv
// ecc_encode
//   Purely combinational extended-Hamming (SECDED) encoder.
//   Ports:
//     data_i  [DataWidth-1:0]  raw data word
//     data_o  [CwWidth:0]      {overall parity, code_word}
//   Code-word positions are 1-based; position n lives in code_word[n-1].
//   Data bits fill the non-power-of-two positions in ascending order and the
//   parity bit at position 2^i covers every position whose index has bit i set.
module ecc_encode
    import ecc_pkg::*;
#(
    parameter  int DataWidth = 64,
    localparam int ParWidth  = get_parity_width(DataWidth),
    localparam int CwWidth   = get_cw_width(DataWidth)
) (
    input  logic [DataWidth-1:0] data_i,
    output logic [CwWidth:0]     data_o
);

    logic [CwWidth-1:0]               w_data_cw;
    logic [ParWidth-1:0][CwWidth-1:0] w_cover;
    logic [ParWidth-1:0]              w_par;
    logic [CwWidth-1:0]               w_cw;

    // Scatter data into non-power-of-two positions. Data index for position g
    // is g minus the count of powers of two <= g, i.e. g - clog2(g+1) - 1.
    for (genvar g = 1; g <= CwWidth; g++) begin : g_pos
        if ((g & (g - 1)) != 0) begin : g_data
            assign w_data_cw[g-1] = data_i[g - $clog2(g + 1) - 1];
            assign w_cw[g-1]      = w_data_cw[g-1];
        end else begin : g_parity
            assign w_data_cw[g-1] = 1'b0;
            assign w_cw[g-1]      = w_par[$clog2(g)];
        end
    end

    // Parity bit i: XOR over the positions whose 1-based index has bit i set.
    // Parity positions hold zero in w_data_cw, so they do not disturb the sum.
    for (genvar i = 0; i < ParWidth; i++) begin : g_par
        for (genvar g = 1; g <= CwWidth; g++) begin : g_cov
            if (((g >> i) % 2) == 1) begin : g_in
                assign w_cover[i][g-1] = w_data_cw[g-1];
            end else begin : g_out
                assign w_cover[i][g-1] = 1'b0;
            end
        end
        assign w_par[i] = ^w_cover[i];
    end

    // Overall parity makes the whole {parity, code_word} word even.
    assign data_o = {^w_cw, w_cw};

endmodule

// File: rtl/ecc_encode_stream.sv
// ecc_encode_stream
//   Registered, valid/ready SECDED encoder for the memory write path with
//   test-only error injection and a counter of output handshakes.
//   Ports:
//     clk_i, rst_ni        clock, asynchronous active-low reset
//     clear_i              synchronous flush of output stage and counter
//     valid_i / ready_o    input beat handshake (ready_o = ~valid_o | ready_i)
//     data_i               raw data word
//     inject_i, inj_pos_i  injection mode and code-word bit index, sampled with the beat
//     valid_o / ready_i    output beat handshake
//     data_o               {overall parity, code_word}
//     beat_cnt_o           output handshakes since reset/clear, wraps at 2^32
module ecc_encode_stream
    import ecc_pkg::*;
#(
    parameter  int DataWidth    = 64,
    parameter  bit EnableInject = 1'b1,
    localparam int CwWidth      = get_cw_width(DataWidth),
    localparam int PosWidth     = $clog2(CwWidth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    input  logic [1:0]           inject_i,
    input  logic [PosWidth-1:0]  inj_pos_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [CwWidth:0]     data_o,
    output logic [31:0]          beat_cnt_o
);

    logic [CwWidth:0] w_enc;
    logic [CwWidth:0] w_inj;
    inj_mode_e        w_mode;
    logic             w_accept;
    logic             w_out_hs;

    logic             r_valid;
    logic [CwWidth:0] r_data;
    logic [31:0]      r_cnt;

    // Flip mask built by shifting so that out-of-range positions simply drop
    // out (guarded explicitly) and the overall-parity bit is never touched
    // by single/double modes.
    function automatic logic [CwWidth:0] apply_inject(
        input logic [CwWidth:0]    word,
        input inj_mode_e           mode,
        input logic [PosWidth-1:0] pos
    );
        logic [CwWidth:0] one;
        logic [CwWidth:0] flip;
        int               p_cur;
        int               p_nxt;
        one   = {{CwWidth{1'b0}}, 1'b1};
        flip  = '0;
        p_cur = int'(pos);
        p_nxt = (p_cur + 1) % CwWidth;
        case (mode)
            INJ_SINGLE: begin
                if (p_cur < CwWidth) flip = one << p_cur;
            end
            INJ_DOUBLE: begin
                if (p_cur < CwWidth) flip = (one << p_cur) | (one << p_nxt);
            end
            INJ_PARITY: begin
                flip[CwWidth] = 1'b1;
            end
            default: begin
                flip = '0;
            end
        endcase
        return word ^ flip;
    endfunction

    ecc_encode #(
        .DataWidth (DataWidth)
    ) u_encode (
        .data_i (data_i),
        .data_o (w_enc)
    );

    assign w_mode   = EnableInject ? inj_mode_e'(inject_i) : INJ_NONE;
    assign w_inj    = apply_inject(w_enc, w_mode, inj_pos_i);

    assign ready_o  = ~r_valid | ready_i;
    assign w_accept = valid_i & ready_o;
    assign w_out_hs = r_valid & ready_i;

    // Output stage: clear wins over accept and handshake; data is left as-is
    // on clear. A handshake coinciding with an accept refills without a bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else if (clear_i) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_data  <= w_inj;
            end else if (w_out_hs) begin
                r_valid <= 1'b0;
            end
            if (w_out_hs) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    assign valid_o    = r_valid;
    assign data_o     = r_data;
    assign beat_cnt_o = r_cnt;

endmodule

// File: tb/tb_ecc_encode_stream.sv
module tb_ecc_encode_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DataWidth = 8 instance (CW = 12)
    logic        d8_clear_i, d8_valid_i, d8_ready_o, d8_valid_o, d8_ready_i;
    logic [7:0]  d8_data_i;
    logic [1:0]  d8_inject_i;
    logic [3:0]  d8_inj_pos_i;
    logic [12:0] d8_data_o;
    logic [31:0] d8_beat_cnt_o;

    // DataWidth = 64 instance (CW = 71)
    logic        d64_clear_i, d64_valid_i, d64_ready_o, d64_valid_o, d64_ready_i;
    logic [63:0] d64_data_i;
    logic [1:0]  d64_inject_i;
    logic [6:0]  d64_inj_pos_i;
    logic [71:0] d64_data_o;
    logic [31:0] d64_beat_cnt_o;

    ecc_encode_stream #(.DataWidth(8), .EnableInject(1'b1)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(d8_clear_i),
        .valid_i(d8_valid_i), .ready_o(d8_ready_o), .data_i(d8_data_i),
        .inject_i(d8_inject_i), .inj_pos_i(d8_inj_pos_i),
        .valid_o(d8_valid_o), .ready_i(d8_ready_i), .data_o(d8_data_o),
        .beat_cnt_o(d8_beat_cnt_o)
    );

    ecc_encode_stream #(.DataWidth(64), .EnableInject(1'b1)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(d64_clear_i),
        .valid_i(d64_valid_i), .ready_o(d64_ready_o), .data_i(d64_data_i),
        .inject_i(d64_inject_i), .inj_pos_i(d64_inj_pos_i),
        .valid_o(d64_valid_o), .ready_i(d64_ready_i), .data_o(d64_data_o),
        .beat_cnt_o(d64_beat_cnt_o)
    );

    int checks   = 0;
    int failures = 0;

    logic [12:0] sb8[$];
    logic [31:0] exp_cnt8;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  m;
        int          p;
    } beat64_t;
    beat64_t sb64[$];

    // Reference encoder for the 8-bit instance, with injection applied.
    function automatic logic [12:0] ref_enc8(input logic [7:0] d, input logic [1:0] m, input int p);
        logic [12:0] w;
        logic        x;
        int          j;
        w = '0;
        j = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w[pos-1] = d[j];
                j++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            x = 1'b0;
            for (int pos = 1; pos <= 12; pos++) begin
                if (((pos >> b) & 1) == 1) x = x ^ w[pos-1];
            end
            w[(1 << b) - 1] = x;
        end
        w[12] = ^w[11:0];
        case (m)
            2'b01: if (p < 12) w[p] = ~w[p];
            2'b10: if (p < 12) begin
                w[p] = ~w[p];
                w[(p + 1) % 12] = ~w[(p + 1) % 12];
            end
            2'b11: w[12] = ~w[12];
            default: ;
        endcase
        return w;
    endfunction

    // SECDED decode of a 64-bit-instance output, judged against the beat sent.
    function automatic bit chk64(input logic [71:0] w, input logic [63:0] d, input logic [1:0] m, input int p);
        logic [70:0] cw;
        logic [63:0] dx;
        logic        ovr;
        int          syn;
        int          j;
        bit          clean;
        cw  = w[70:0];
        ovr = ^w;
        syn = 0;
        for (int pos = 1; pos <= 71; pos++) begin
            if (cw[pos-1]) syn = syn ^ pos;
        end
        if (ovr && syn >= 1 && syn <= 71) cw[syn-1] = ~cw[syn-1];
        j  = 0;
        dx = '0;
        for (int pos = 1; pos <= 71; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                dx[j] = cw[pos-1];
                j++;
            end
        end
        clean = (syn == 0) && !ovr && (dx == d);
        case (m)
            2'b00:   return clean;
            2'b01:   return (p >= 71) ? clean : ((syn == p + 1) && ovr && (dx == d));
            2'b10:   return (p >= 71) ? clean : ((syn != 0) && !ovr);
            default: return (syn == 0) && ovr && (dx == d);
        endcase
    endfunction

    // Drive one cycle on the 8-bit instance and run the scoreboard bookkeeping.
    task automatic step8(
        input  logic        vld,
        input  logic [7:0]  din,
        input  logic [1:0]  inj,
        input  logic [3:0]  pos,
        input  logic        rdy,
        input  logic        clr,
        input  logic [12:0] exp_word,
        output logic        hs,
        output logic [12:0] got,
        output logic [12:0] want,
        output logic        popped
    );
        @(negedge clk);
        d8_valid_i   = vld;
        d8_data_i    = din;
        d8_inject_i  = inj;
        d8_inj_pos_i = pos;
        d8_ready_i   = rdy;
        d8_clear_i   = clr;
        #1;
        hs     = d8_valid_o & d8_ready_i;
        got    = d8_data_o;
        want   = '0;
        popped = 1'b0;
        if (hs && sb8.size() > 0) begin
            want   = sb8.pop_front();
            popped = 1'b1;
        end
        if (vld && d8_ready_o && !clr) sb8.push_back(exp_word);
        if (clr) exp_cnt8 = '0;
        else if (hs) exp_cnt8 = exp_cnt8 + 32'd1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sb8.delete();
        sb64.delete();
        exp_cnt8 = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if (d8_valid_o !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got=%b want=0", d8_valid_o);
        end
        checks++;
        if (d8_data_o !== 13'h0) begin
            failures++; $display("FAIL reset_data: got=%h want=0000", d8_data_o);
        end
        checks++;
        if (d8_beat_cnt_o !== 32'h0) begin
            failures++; $display("FAIL reset_cnt: got=%0d want=0", d8_beat_cnt_o);
        end
        checks++;
        if (d8_ready_o !== 1'b1) begin
            failures++; $display("FAIL reset_ready: got=%b want=1", d8_ready_o);
        end
    endtask

    task automatic test_vectors8();
        logic [7:0]  vd[7] = '{8'hFF, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        logic [1:0]  vm[7] = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b10};
        logic [3:0]  vp[7] = '{4'd0, 4'd0, 4'd4, 4'd0, 4'd11, 4'd13, 4'd5};
        logic [12:0] vw[7] = '{13'h0F77, 13'h1007, 13'h1017, 13'h0007, 13'h1806, 13'h1007, 13'h1067};
        logic hs, popped;
        logic [12:0] got, want;
        for (int k = 0; k < 7; k++) begin
            step8(1'b1, vd[k], vm[k], vp[k], 1'b1, 1'b0, vw[k], hs, got, want, popped);
            if (k == 1) begin
                checks++;
                if (d8_valid_o !== 1'b1) begin
                    failures++; $display("FAIL vec_latency: valid_o=%b want=1", d8_valid_o);
                end
            end
            if (hs) begin
                checks++;
                if (!popped || got !== want) begin
                    failures++; $display("FAIL vec_word: got=%h want=%h popped=%0d", got, want, popped);
                end
            end
        end
        for (int k = 0; k < 20 && sb8.size() > 0; k++) begin
            step8(1'b0, 8'h0, 2'b00, 4'd0, 1'b1, 1'b0, 13'h0, hs, got, want, popped);
            if (hs) begin
                checks++;
                if (!popped || got !== want) begin
                    failures++; $display("FAIL vec_word: got=%h want=%h popped=%0d", got, want, popped);
                end
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (sb8.size() != 0 || d8_beat_cnt_o !== exp_cnt8) begin
            failures++; $display("FAIL vec_count: cnt=%0d want=%0d left=%0d", d8_beat_cnt_o, exp_cnt8, sb8.size());
        end
    endtask

    task automatic test_back_to_back();
        logic hs, popped;
        logic [12:0] got, want, a_word;
        logic [7:0]  d;
        logic [1:0]  m;
        logic [3:0]  p;
        a_word = ref_enc8(8'hA5, 2'b00, 0);
        step8(1'b1, 8'hA5, 2'b00, 4'd0, 1'b1, 1'b0, a_word, hs, got, want, popped);
        for (int k = 0; k < 5; k++) begin
            step8(1'b1, 8'h3C, 2'b00, 4'd0, 1'b0, 1'b0, ref_enc8(8'h3C, 2'b00, 0), hs, got, want, popped);
            checks++;
            if (d8_ready_o !== 1'b0 || d8_valid_o !== 1'b1 || got !== a_word) begin
                failures++;
                $display("FAIL bp_hold: ready_o=%b valid_o=%b data=%h want ready_o=0 valid_o=1 data=%h",
                         d8_ready_o, d8_valid_o, got, a_word);
            end
        end
        for (int k = 0; k < 12; k++) begin
            d = (k == 0) ? 8'h3C : 8'($urandom);
            m = 2'($urandom);
            p = 4'($urandom);
            step8(1'b1, d, m, p, 1'b1, 1'b0, ref_enc8(d, m, int'(p)), hs, got, want, popped);
            if (hs) begin
                checks++;
                if (!popped || got !== want) begin
                    failures++; $display("FAIL b2b_word: got=%h want=%h popped=%0d", got, want, popped);
                end
            end
        end
        for (int k = 0; k < 20 && sb8.size() > 0; k++) begin
            step8(1'b0, 8'h0, 2'b00, 4'd0, 1'b1, 1'b0, 13'h0, hs, got, want, popped);
            if (hs) begin
                checks++;
                if (!popped || got !== want) begin
                    failures++; $display("FAIL b2b_word: got=%h want=%h popped=%0d", got, want, popped);
                end
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (sb8.size() != 0 || d8_beat_cnt_o !== exp_cnt8) begin
            failures++; $display("FAIL b2b_count: cnt=%0d want=%0d left=%0d", d8_beat_cnt_o, exp_cnt8, sb8.size());
        end
    endtask

    task automatic test_clear();
        logic hs, popped;
        logic [12:0] got, want, x_word;
        x_word = ref_enc8(8'h5A, 2'b00, 0);
        step8(1'b1, 8'h5A, 2'b00, 4'd0, 1'b0, 1'b0, x_word, hs, got, want, popped);
        step8(1'b1, 8'h11, 2'b00, 4'd0, 1'b0, 1'b0, ref_enc8(8'h11, 2'b00, 0), hs, got, want, popped);
        step8(1'b1, 8'h22, 2'b00, 4'd0, 1'b1, 1'b1, ref_enc8(8'h22, 2'b00, 0), hs, got, want, popped);
        checks++;
        if (d8_ready_o !== 1'b1 || !hs || !popped || got !== want) begin
            failures++; $display("FAIL clear_hs: ready_o=%b hs=%b data=%h want ready_o=1 hs=1 data=%h",
                                 d8_ready_o, hs, got, want);
        end
        step8(1'b0, 8'h0, 2'b00, 4'd0, 1'b1, 1'b0, 13'h0, hs, got, want, popped);
        checks++;
        if (d8_valid_o !== 1'b0 || d8_beat_cnt_o !== 32'h0 || got !== x_word) begin
            failures++; $display("FAIL clear_flush: valid_o=%b cnt=%0d data=%h want valid_o=0 cnt=0 data=%h",
                                 d8_valid_o, d8_beat_cnt_o, got, x_word);
        end
        for (int k = 0; k < 3; k++) begin
            step8(1'b0, 8'h0, 2'b00, 4'd0, 1'b1, 1'b0, 13'h0, hs, got, want, popped);
            checks++;
            if (d8_valid_o !== 1'b0 || sb8.size() != 0) begin
                failures++; $display("FAIL clear_drop: valid_o=%b left=%0d want valid_o=0 left=0",
                                     d8_valid_o, sb8.size());
            end
        end
    endtask

    task automatic test_async_reset();
        logic hs, popped;
        logic [12:0] got, want;
        for (int k = 0; k < 3; k++) begin
            step8(1'b1, 8'(k + 7), 2'b00, 4'd0, 1'b1, 1'b0, ref_enc8(8'(k + 7), 2'b00, 0), hs, got, want, popped);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (d8_valid_o !== 1'b0 || d8_beat_cnt_o !== 32'h0 || d8_data_o !== 13'h0 || d8_ready_o !== 1'b1) begin
            failures++; $display("FAIL async_reset: valid_o=%b cnt=%0d data=%h ready_o=%b want 0/0/0000/1",
                                 d8_valid_o, d8_beat_cnt_o, d8_data_o, d8_ready_o);
        end
        d8_valid_i = 1'b0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        sb8.delete();
        exp_cnt8 = '0;
    endtask

    task automatic test_wrap();
        logic hs, popped;
        logic [12:0] got, want;
        @(negedge clk);
        force dut8.r_cnt = 32'hFFFF_FFFF;
        #1;
        release dut8.r_cnt;
        exp_cnt8 = 32'hFFFF_FFFF;
        step8(1'b1, 8'hC3, 2'b00, 4'd0, 1'b1, 1'b0, ref_enc8(8'hC3, 2'b00, 0), hs, got, want, popped);
        checks++;
        if (d8_beat_cnt_o !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL wrap_preset: cnt=%h want=ffffffff", d8_beat_cnt_o);
        end
        step8(1'b0, 8'h0, 2'b00, 4'd0, 1'b1, 1'b0, 13'h0, hs, got, want, popped);
        checks++;
        if (!hs || !popped || got !== want) begin
            failures++; $display("FAIL wrap_word: hs=%b got=%h want=%h", hs, got, want);
        end
        @(negedge clk);
        #1;
        checks++;
        if (d8_beat_cnt_o !== 32'h0 || exp_cnt8 !== 32'h0) begin
            failures++; $display("FAIL wrap_count: cnt=%h want=00000000", d8_beat_cnt_o);
        end
    endtask

    task automatic test_inject64();
        int      sent;
        logic    vld;
        beat64_t b;
        beat64_t e;
        sent = 0;
        for (int cyc = 0; cyc < 5000 && (sent < 1000 || sb64.size() > 0); cyc++) begin
            @(negedge clk);
            vld    = (sent < 1000) && ($urandom_range(0, 3) != 0);
            b.d    = {$urandom, $urandom};
            b.m    = 2'($urandom_range(0, 3));
            b.p    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(71, 127)) : int'($urandom_range(0, 70));
            d64_valid_i   = vld;
            d64_data_i    = b.d;
            d64_inject_i  = b.m;
            d64_inj_pos_i = 7'(b.p);
            d64_ready_i   = ($urandom_range(0, 3) != 0);
            #1;
            if (d64_valid_o && d64_ready_i) begin
                checks++;
                if (sb64.size() == 0) begin
                    failures++; $display("FAIL inj64_extra: unexpected beat data=%h", d64_data_o);
                end else begin
                    e = sb64.pop_front();
                    if (!chk64(d64_data_o, e.d, e.m, e.p)) begin
                        failures++;
                        $display("FAIL inj64_decode: word=%h data=%h mode=%0d pos=%0d", d64_data_o, e.d, e.m, e.p);
                    end
                end
            end
            if (vld && d64_ready_o) begin
                sb64.push_back(b);
                sent++;
            end
        end
        d64_valid_i = 1'b0;
        checks++;
        if (sent != 1000 || sb64.size() != 0) begin
            failures++; $display("FAIL inj64_timeout: sent=%0d left=%0d want sent=1000 left=0", sent, sb64.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        d8_clear_i = 1'b0; d8_valid_i = 1'b0; d8_ready_i = 1'b1;
        d8_data_i = '0; d8_inject_i = '0; d8_inj_pos_i = '0;
        d64_clear_i = 1'b0; d64_valid_i = 1'b0; d64_ready_i = 1'b1;
        d64_data_i = '0; d64_inject_i = '0; d64_inj_pos_i = '0;
        exp_cnt8 = '0;
        do_reset();
        test_reset();
        test_vectors8();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_wrap();
        test_inject64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecc_encode_stream.md
Name: ecc_encode_stream

Overview:
Registered, valid/ready-handshaked SECDED Hamming encoder for the memory write path. It is the transmit-side counterpart of the SECDED decoder used on the read path. It accepts raw data beats, produces the extended Hamming code word plus overall parity bit, and holds the result in an output stage until downstream accepts it. Test-only error injection and an accepted-beat counter support end-to-end checks of the decoder.

Parameters:
DataWidth, 64, width of unencoded data word (>= 1)
EnableInject, 1'b1, 1 = error-injection logic present; 0 = inject_i ignored, tied off

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
clear_i  input  1  synchronous flush of output stage and counter
valid_i  input  1  input beat valid
ready_o  output  1  encoder can accept a beat
data_i  input  DataWidth  raw data
inject_i  input  2  injection mode, sampled with the beat: 00 none, 01 single, 10 double, 11 overall-parity
inj_pos_i  input  $clog2(CW)  code-word bit index for injection (CW = get_cw_width(DataWidth))
valid_o  output  1  encoded beat valid
ready_i  input  1  downstream accepts
data_o  output  CW+1  {parity, code_word}
beat_cnt_o  output  32  number of output handshakes since reset/clear

Behaviour:
- Reset (rst_ni low, async): valid_o=0, data_o='0, beat_cnt_o=0; ready_o=1 as soon as reset releases.
- Encoding rules:
  - p = smallest integer with 2^p >= DataWidth+p+1; CW = DataWidth+p.
  - Code-word positions are 1-based. Data bits fill the non-power-of-two positions in ascending order (data_i[0] at position 3).
  - Parity bit i sits at position 2^i and is the XOR of all positions whose index has bit i set.
  - Overall parity (MSB of data_o) is the XOR of all CW bits, so the full output has even parity.
- Injection is applied after encoding, to the stored word only:
  - 01: flip code_word[inj_pos_i].
  - 10: flip inj_pos_i and (inj_pos_i+1) mod CW.
  - 11: flip the MSB parity bit only.
  - inj_pos_i >= CW with mode 01/10: no flip.
  - EnableInject=0: inject_i and inj_pos_i are ignored.
- Handshake:
  - Single output register; ready_o = ~valid_o | ready_i (combinational path from ready_i is allowed).
  - Accept on valid_i & ready_o; the word appears on data_o the next cycle. Latency 1, throughput 1 beat/cycle.
  - While valid_o & ~ready_i: data_o and valid_o stay stable.
  - valid_o must not depend on ready_i.
  - Inputs are don't-care when valid_i=0.
- beat_cnt_o increments on each valid_o & ready_i and wraps 0xFFFF_FFFF -> 0.
- clear_i has priority over everything:
  - Next cycle valid_o=0 and beat_cnt_o=0; data_o is unchanged.
  - An input beat presented in the same cycle is dropped; ready_o remains asserted per the formula.
  - An output handshake in the same cycle still completes downstream, but is not counted.
- Simultaneous output handshake and input accept: the register is overwritten with the new word, valid_o stays 1, and no bubble appears.

Decomposition:
- ecc_pkg: get_parity_width(), get_cw_width(), inject-mode enum (INJ_NONE, INJ_SINGLE, INJ_DOUBLE, INJ_PARITY). Reuse the existing functions; do not duplicate them.
- Sub-module ecc_encode: purely combinational encoder (data_i -> {parity, code_word}).
- This block adds the register stage, handshake, injection and counter around ecc_encode.

Test Plan:
- DataWidth=8: data_i=0xFF, inject 00, ready_i=1 -> data_o=13'h0F77 one cycle later, beat_cnt_o=1.
- DataWidth=8: data_i=0x01 -> data_o=13'h1007. Same beat with inject 01, inj_pos_i=4 -> 13'h1017. With inject 11 -> 13'h0007.
- DataWidth=64, 1000 random beats through the existing decoder: inject 00 -> no error flags, data matches. Inject 01 -> single_error_o, data corrected. Inject 10 -> double_error_o. Inject 11 -> parity_error_o only.
- Backpressure: ready_i=0 for 5 cycles with valid_i=1 held -> data_o stable, ready_o=0. Release -> back-to-back beats, no loss or duplication, beat_cnt_o equals the number of beats sent.
- clear_i asserted with valid_o=1, valid_i=1 -> next cycle valid_o=0, beat_cnt_o=0, input beat not emitted.
- Async reset mid-stream (rst_ni low between clock edges) -> valid_o=0 and beat_cnt_o=0 immediately. Force beat_cnt_o to 0xFFFF_FFFF, then one handshake -> 0.
